// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: memory request/response channel, decoder instruction
// channel and the redirect sideband. No logic, so no latency and no
// backpressure of its own.
//
// master: the fetch unit (drives requests, instructions)
// slave : the environment (memory + decoder + branch unit)
interface instr_fetch_if;
  // instruction memory request / response
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  // decoder side
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  // branch/jump redirect
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch_fifo: generic synchronous FIFO with a flush, head always visible.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes into a full FIFO without a same-cycle pop are ignored.
//
// Ports: clk/rst, flush_i (clears contents, wins over push/pop),
//        push_i/push_dat_i, pop_i, head_dat_o, count_o (entries held).
module instr_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    // full + pop + push is fine: the slot being vacated is reused
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: count_o gates every use of the head
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// instr_fetch: PC keeper and instruction-memory fetcher feeding the decoder.
// Latency: request accepted at t -> earliest response t+1 -> instr_valid t+2.
// Backpressure: requests stop once DEPTH words are owed or buffered; a stalled
//               decoder holds instr/instr_pc stable.
//
// Ports: clk, rst (async, active-high); bus (instr_fetch_if.master):
//   imem_req_valid/ready/addr, imem_resp_valid/data  - memory channel
//   instr_valid/ready, instr, instr_pc               - decoder channel
//   redirect, redirect_pc                            - flush + new fetch PC
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } ent_t;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  // responses still owed from before the last redirect; they are discarded
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  ent_t          fifo_head;
  ent_t          fifo_push_dat;
  logic          fifo_push, fifo_pop, fifo_empty;

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_tgt;
  logic          req_vld, req_fire, resp_vld;

  assign redirect_tgt = bus.redirect_pc & ~32'h3;
  assign resp_vld     = bus.imem_resp_valid;

  always_comb begin
    // drop-pending requests will be thrown away, so they hold no slot
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - {1'b0, drop_q};
    // rst gating keeps the request low while reset is held
    req_vld     = !rst && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
    req_fire    = req_vld && bus.imem_req_ready;
    fifo_empty  = (fifo_count == '0);
    fifo_pop    = !fifo_empty && !bus.redirect && bus.instr_ready;
    fifo_push   = resp_vld && (drop_q == '0) && !bus.redirect;
    fifo_push_dat.dat = bus.imem_resp_data;
    fifo_push_dat.pc  = resp_pc_q;

    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_vld);

    if (bus.redirect) begin
      pc_d      = redirect_tgt;
      resp_pc_d = redirect_tgt;
      // everything still in flight is stale, minus one arriving right now
      drop_d    = outstanding_q - CW'(resp_vld);
    end else begin
      if (req_fire)  pc_d      = pc_q + 32'd4;
      if (fifo_push) resp_pc_d = resp_pc_q + 32'd4;
      if (resp_vld && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  instr_fetch_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.redirect),
    .push_i     (fifo_push),
    .push_dat_i (fifo_push_dat),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .count_o    (fifo_count)
  );

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = !fifo_empty && !bus.redirect;
  assign bus.instr          = fifo_empty ? NOP   : fifo_head.dat;
  assign bus.instr_pc       = fifo_empty ? 32'h0 : fifo_head.pc;

  // the credit rule leaves room for every live response
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_vld && (drop_q == '0) && (fifo_count == CW'(DEPTH))));
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(resp_vld && (outstanding_q == '0)));
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: accepted requests waiting to be answered, in order
  typedef struct {
    logic [31:0] addr;
    int          ep;
    longint      due;
  } mreq_t;
  mreq_t mq[$];

  // reference: live words the decoder should see, in order
  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;
  ent_t        eq[$];
  int          epoch   = 0;
  int          live    = 0;   // accepted since last flush, not yet consumed
  logic [31:0] next_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_flush(input logic [31:0] tgt);
    eq.delete();
    epoch++;
    live    = 0;
    next_pc = tgt & ~32'h3;
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit ir,
                      input bit qr, input int lat_lo, input int lat_hi);
    bit          e_req, e_ivld, resp, stale;
    mreq_t       r;
    @(negedge clk);
    bus.redirect       = rd;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = ir;
    bus.imem_req_ready = qr;
    resp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(mq[0].addr) : $urandom;
    #1;
    e_req  = !rd && (live < DEPTH);
    e_ivld = !rd && (eq.size() > 0);
    check("req_valid",   32'(bus.imem_req_valid), 32'(e_req));
    check("req_addr",    bus.imem_req_addr,       next_pc);
    check("instr_valid", 32'(bus.instr_valid),    32'(e_ivld));
    check("instr",       bus.instr,    (eq.size() > 0) ? eq[0].dat : NOP);
    check("instr_pc",    bus.instr_pc, (eq.size() > 0) ? eq[0].pc  : 32'h0);

    // advance the reference by this cycle's events
    if (resp) begin
      r = mq.pop_front();
      stale = (r.ep != epoch) || rd;
    end
    if (e_ivld && ir) begin
      void'(eq.pop_front());
      live--;
    end
    if (rd) begin
      model_flush(rpc);
    end else begin
      if (resp && !stale) eq.push_back('{pc: r.addr, dat: mem_word(r.addr)});
      if (e_req && qr) begin
        mq.push_back('{addr: next_pc, ep: epoch,
                       due: cyc + longint'($urandom_range(lat_hi, lat_lo))});
        next_pc = next_pc + 32'd4;
        live++;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.redirect        = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"},   32'(bus.imem_req_valid), 32'h0);
    check({pfx, "_req_addr"},    bus.imem_req_addr,       RESET_PC);
    check({pfx, "_instr_valid"}, 32'(bus.instr_valid),    32'h0);
    check({pfx, "_instr"},       bus.instr,               NOP);
    check({pfx, "_instr_pc"},    bus.instr_pc,            32'h0);
  endtask

  // asynchronous reset in the middle of a cycle, outputs checked at once
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    mq.delete();
    model_flush(RESET_PC);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // streaming, 1-cycle memory, decoder always ready
    repeat (24) step(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
    // decoder stall fills the buffer, then drains without loss
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
    repeat (8)  step(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
    // redirect to 0x100 with requests in flight at latency 3
    repeat (4)  step(1'b0, 32'h0, 1'b1, 1'b1, 3, 3);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 3, 3);
    repeat (16) step(1'b0, 32'h0, 1'b1, 1'b1, 3, 3);
    // frequent redirects at latency 1 (collide with arrivals and pops)
    for (int i = 0; i < 60; i++)
      step((i % 5) == 2, $urandom, 1'b1, 1'b1, 1, 1);
    // back-to-back redirects
    step(1'b1, 32'h0000_0400, 1'b1, 1'b1, 2, 2);
    step(1'b1, 32'h0000_0800, 1'b1, 1'b1, 2, 2);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 2, 2);
    // unaligned target is word-aligned; PC wraps past 0xFFFF_FFFC
    step(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1, 1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
    step(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1, 1, 1);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(19, 0) == 0, $urandom, ($urandom_range(3, 0) != 0),
           ($urandom_range(2, 0) != 0), 1, 4);

    // reset with buffer full and stale requests in flight
    step(1'b1, 32'h0000_1000, 1'b0, 1'b1, 3, 3);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 3, 3);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 3, 3);
    mid_reset();
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1, 2, 2);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) == 0, $urandom, $urandom_range(1, 0) == 1,
           1'b1, 1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Producer end of the decoder's 32-bit instruction input. Keeps the PC and issues word requests to instruction memory. Buffers the in-order responses in a small FIFO, tagged with their PC, and presents them to the decoder with a valid/ready handshake. A branch/jump redirect flushes everything in flight and restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
DEPTH, 2, FIFO entries; also the cap on requests in flight plus entries buffered (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address of request, bits[1:0]=0
imem_resp_valid  input  1  response word valid; responses return in request order, >=1 cycle after acceptance
imem_resp_data  input  32  instruction word
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr_ready  input  1  decoder consumes instr
instr  output  32  instruction to decoder
instr_pc  output  32  PC of instr
redirect  input  1  flush and restart fetch (taken branch/jump)
redirect_pc  input  32  new fetch PC; bits[1:0] ignored and treated as 0

Behaviour:
- Reset (async, any time, including mid-transfer): pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
- Reset output values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0.
- Counter widths: outstanding and drop use clog2(DEPTH+1) bits.
- Credit: imem_req_valid = !redirect && (outstanding + fifo_count - drop) < DEPTH. Drop-pending slots are free because those responses are discarded.
- imem_req_addr = pc.
- Request accept: on imem_req_valid && imem_req_ready, pc += 4 (wraps mod 2^32) and outstanding += 1.
- Response arrival: each imem_resp_valid decrements outstanding.
  - If drop>0: the response is discarded and drop -= 1.
  - Otherwise {imem_resp_data, resp_pc} is written to the FIFO and resp_pc += 4.
  - No bypass: the word is visible on instr the cycle after arrival.
  - Minimum latency: request accepted at t, response at t+1, instr_valid at t+2.
- Output handshake:
  - instr_valid = FIFO non-empty && !redirect.
  - instr/instr_pc = FIFO head; when empty, instr is NOP (32'h0000_0013) and instr_pc is 0.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle keep fifo_count unchanged; with a full FIFO, simultaneous pop+push is legal.
- Redirect cycle (redirect=1):
  - No request is issued.
  - The FIFO is cleared; any head in that cycle is not consumed, since instr_valid=0.
  - drop <= outstanding minus 1 if a response arrives in that same cycle (that response is also discarded).
  - pc and resp_pc are both set to {redirect_pc[31:2],2'b00}.
  - Fetch resumes at the next cycle.
- Back-to-back redirects: each one reloads the PCs, and drop accumulates correctly (drop always equals the responses still owed).
- Overflow is impossible by the credit rule. A response arriving with the FIFO full and drop=0 is a protocol violation; flag it with an assertion.
- Stall: instr_ready=0 holds instr/instr_pc stable. Once DEPTH entries are buffered, imem_req_valid falls to 0.

Test Plan:
- Reset release, memory with 1-cycle latency, always ready, instr_ready=1 -> requests 0x0,0x4,0x8,...; instr_valid first high 2 cycles after first accept; instr_pc sequence 0x0,0x4,0x8 matching the data words.
- instr_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 entries buffered, imem_req_valid=0, instr held at the PC 0x0 word; on release, 0x0 then 0x4 delivered without loss.
- Redirect to 0x100 with 2 requests in flight (latency 3) -> both stale responses dropped; next instr_pc=0x100; no instruction from 0x8/0xC ever appears.
- Redirect in the same cycle a response arrives and the decoder pops -> instr_valid=0 that cycle, response discarded, drop=outstanding-1, next delivered instr_pc=redirect target.
- redirect_pc=0x203 -> imem_req_addr=0x200; PC at 0xFFFF_FFFC wraps, next request addr 0x0.
- Assert rst mid-stream with FIFO full and requests in flight -> all outputs at reset values the same cycle; after release, fetch restarts at RESET_PC with stale responses not delivered.
